gb_cpu_interrupt_ctrl: RTL and testbench

Owns IME, IF (0xFF0F) and IE (0xFFFF), resolves interrupt priority, and sequences the 5-M-cycle dispatch. Sits directly upstream of the register file and drives its interrupt_queued, interrupt_queued_no_IME, enable_interrupts_delayed, halt_bug_delay, write_interrupt_vector and interrupt_vector inputs. Also exposes the dispatch state to the control unit. One clk edge equals one M-cycle.

---
 rtl/gb_cpu_common_pkg.sv | 29 ++
 rtl/gb_cpu_irq_priority.sv | 32 +++
 rtl/gb_cpu_interrupt_ctrl.sv | 178 +++++++++++++++++
 tb/tb_gb_cpu_interrupt_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the CPU interrupt controller.
package gb_cpu_common_pkg;

  // Interrupt dispatch sequence, one M-cycle per state.
  typedef enum logic [2:0] {
    DS_IDLE    = 3'd0,
    DS_WAIT    = 3'd1,
    DS_DEC_SP  = 3'd2,
    DS_PUSH_HI = 3'd3,
    DS_PUSH_LO = 3'd4,
    DS_JUMP    = 3'd5
  } dispatch_state_t;

  localparam logic [15:0] IF_ADDR = 16'hFF0F;
  localparam logic [15:0] IE_ADDR = 16'hFFFF;

  // Returns {valid, index} of the lowest set bit; bit 0 has the highest priority.
  function automatic logic [3:0] irqPriorityVector(input logic [4:0] pend);
    logic [3:0] result;
    result = 4'b0000;
    for (int i = 4; i >= 0; i--) begin
      if (pend[i]) begin
        result = {1'b1, 3'(i)};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/gb_cpu_irq_priority.sv
// Lowest-bit priority encoder plus vector adder for the interrupt sources.
module gb_cpu_irq_priority
  import gb_cpu_common_pkg::*;
#(
  parameter int          NUM_IRQ     = 5,
  parameter logic [7:0]  VECTOR_BASE = 8'h40
) (
  input  logic [NUM_IRQ-1:0] pend_i,
  output logic               valid_o,
  output logic [2:0]         index_o,
  output logic [7:0]         vector_o
);

  logic [4:0] pend_pad;
  logic [3:0] prio;

  // Widen the request set to the encoder's fixed five inputs.
  for (genvar gi = 0; gi < 5; gi++) begin : g_pad
    if (gi < NUM_IRQ) begin : g_used
      assign pend_pad[gi] = pend_i[gi];
    end else begin : g_unused
      assign pend_pad[gi] = 1'b0;
    end
  end

  assign prio     = irqPriorityVector(pend_pad);
  assign valid_o  = prio[3];
  assign index_o  = prio[2:0];
  // Source n jumps to VECTOR_BASE + 8*n.
  assign vector_o = VECTOR_BASE + {2'b00, prio[2:0], 3'b000};

endmodule

// File: rtl/gb_cpu_interrupt_ctrl.sv
// IME / IF / IE ownership, priority resolution and the 5-M-cycle dispatch sequencer.
module gb_cpu_interrupt_ctrl
  import gb_cpu_common_pkg::*;
#(
  parameter int         NUM_IRQ     = 5,
  parameter logic [7:0] VECTOR_BASE = 8'h40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [15:0]        bus_addr,
  input  logic [7:0]         bus_wdata,
  input  logic               bus_wren,
  output logic [7:0]         bus_rdata,
  input  logic               ei,
  input  logic               di,
  input  logic               reti,
  input  logic               halt,
  input  logic               last_m_cycle,
  output logic               interrupt_queued,
  output logic               interrupt_queued_no_IME,
  output logic               enable_interrupts_delayed,
  output logic               halt_bug_delay,
  output logic               write_interrupt_vector,
  output logic [7:0]         interrupt_vector,
  output logic [2:0]         dispatch_state,
  output logic               ime
);

  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic               ime_q, ime_d;
  logic               ei_pending_q, ei_pending_d;
  logic [7:0]         vector_q, vector_d;
  logic               halt_cond_q;
  dispatch_state_t    state_q, state_d;

  logic [NUM_IRQ-1:0] pend_bits;
  logic [NUM_IRQ-1:0] clr_mask;
  logic               pending;
  logic [2:0]         prio_index;
  logic [7:0]         prio_vector;
  logic               dispatching;
  logic               dispatch_start;
  logic               halt_cond;
  logic               if_wr;
  logic               ie_wr;

  assign pend_bits   = ie_q[NUM_IRQ-1:0] & if_q;
  assign dispatching = (state_q != DS_IDLE);
  assign if_wr       = bus_wren && (bus_addr == IF_ADDR);
  assign ie_wr       = bus_wren && (bus_addr == IE_ADDR);

  // Same encoder drives the pending flag and the vector chosen at push-low.
  gb_cpu_irq_priority #(
    .NUM_IRQ    (NUM_IRQ),
    .VECTOR_BASE(VECTOR_BASE)
  ) u_prio (
    .pend_i  (pend_bits),
    .valid_o (pending),
    .index_o (prio_index),
    .vector_o(prio_vector)
  );

  // One-hot clear for the IF bit being serviced.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_clr
    assign clr_mask[gi] = pending && (prio_index == 3'(gi));
  end

  // Dispatch sequencer: start on an instruction boundary or out of HALT.
  always_comb begin
    state_d        = state_q;
    dispatch_start = 1'b0;
    case (state_q)
      DS_IDLE: begin
        if (ime_q && pending && (last_m_cycle || halt)) begin
          state_d        = DS_WAIT;
          dispatch_start = 1'b1;
        end
      end
      DS_WAIT:    state_d = DS_DEC_SP;
      DS_DEC_SP:  state_d = DS_PUSH_HI;
      DS_PUSH_HI: state_d = DS_PUSH_LO;
      DS_PUSH_LO: state_d = DS_JUMP;
      DS_JUMP:    state_d = DS_IDLE;
      default:    state_d = DS_IDLE;
    endcase
  end

  // Register next-state: IF write/clear/request ordering, IE, IME/EI delay, vector latch.
  always_comb begin
    if_d         = if_q;
    ie_d         = ie_q;
    ime_d        = ime_q;
    ei_pending_d = ei_pending_q;
    vector_d     = vector_q;

    if (if_wr) begin
      if_d = bus_wdata[NUM_IRQ-1:0];
    end
    // Priority is re-resolved here so an IE write during push-high can cancel.
    if (state_q == DS_PUSH_LO) begin
      if (pending) begin
        vector_d = prio_vector;
        if_d     = if_d & ~clr_mask;
      end else begin
        vector_d = 8'h00;
      end
    end
    // A same-cycle request beats both the bus write and the dispatch clear.
    if_d = if_d | irq_req;

    if (ie_wr) begin
      ie_d = bus_wdata;
    end

    if (dispatch_start) begin
      // Entering the handler supersedes any IME effect of the finishing instruction.
      ime_d        = 1'b0;
      ei_pending_d = 1'b0;
    end else if (!dispatching && last_m_cycle) begin
      if (di) begin
        ime_d        = 1'b0;
        ei_pending_d = 1'b0;
      end else begin
        // The instruction after EI completes the delay; a second EI re-arms the window.
        if (ei_pending_q || reti) begin
          ime_d = 1'b1;
        end
        ei_pending_d = ei;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_q         <= '0;
      ie_q         <= 8'h00;
      ime_q        <= 1'b0;
      ei_pending_q <= 1'b0;
      vector_q     <= 8'h00;
      halt_cond_q  <= 1'b0;
      state_q      <= DS_IDLE;
    end else begin
      if_q         <= if_d;
      ie_q         <= ie_d;
      ime_q        <= ime_d;
      ei_pending_q <= ei_pending_d;
      vector_q     <= vector_d;
      halt_cond_q  <= halt_cond;
      state_q      <= state_d;
    end
  end

  // Register reads are combinational; unmapped addresses float high.
  always_comb begin
    bus_rdata = 8'hFF;
    if (bus_addr == IF_ADDR) begin
      bus_rdata[NUM_IRQ-1:0] = if_q;
    end else if (bus_addr == IE_ADDR) begin
      bus_rdata = ie_q;
    end
  end

  // Halt bug fires once on the first cycle the condition holds.
  assign halt_cond = halt && !ime_q && pending && !ei_pending_q && !dispatching;
  assign halt_bug_delay = halt_cond && !halt_cond_q;

  assign interrupt_queued          = ime_q && pending && !dispatching;
  assign interrupt_queued_no_IME   = !ime_q && pending;
  assign enable_interrupts_delayed = ei_pending_q;
  assign write_interrupt_vector    = (state_q == DS_JUMP);
  assign interrupt_vector          = vector_q;
  assign dispatch_state            = state_q;
  assign ime                       = ime_q;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Directed scenarios plus random traffic, checked each cycle against a behavioural model.
module tb_gb_cpu_interrupt_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  irq_req;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_wren;
  logic [7:0]  bus_rdata;
  logic        ei, di, reti, halt, last_m_cycle;
  logic        interrupt_queued, interrupt_queued_no_IME, enable_interrupts_delayed;
  logic        halt_bug_delay, write_interrupt_vector;
  logic [7:0]  interrupt_vector;
  logic [2:0]  dispatch_state;
  logic        ime;

  int errors;
  int checks;
  bit chk_en;

  // Reference model state.
  bit [4:0] m_if;
  bit [7:0] m_ie;
  bit       m_ime, m_eip, m_hbprev;
  int       m_phase;   // 0 = idle, 1..5 = dispatch M-cycle number
  bit [7:0] m_vec;

  gb_cpu_interrupt_ctrl dut (
    .clk                      (clk),
    .reset                    (reset),
    .irq_req                  (irq_req),
    .bus_addr                 (bus_addr),
    .bus_wdata                (bus_wdata),
    .bus_wren                 (bus_wren),
    .bus_rdata                (bus_rdata),
    .ei                       (ei),
    .di                       (di),
    .reti                     (reti),
    .halt                     (halt),
    .last_m_cycle             (last_m_cycle),
    .interrupt_queued         (interrupt_queued),
    .interrupt_queued_no_IME  (interrupt_queued_no_IME),
    .enable_interrupts_delayed(enable_interrupts_delayed),
    .halt_bug_delay           (halt_bug_delay),
    .write_interrupt_vector   (write_interrupt_vector),
    .interrupt_vector         (interrupt_vector),
    .dispatch_state           (dispatch_state),
    .ime                      (ime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input bit [4:0] v);
    for (int i = 0; i < 5; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Compare every output against what the model predicts for this cycle.
  task automatic compare_all();
    bit [4:0] pend;
    bit       p;
    bit       cond;
    bit [7:0] rd;
    pend = m_ie[4:0] & m_if;
    p    = (pend != 5'd0);
    cond = halt && !m_ime && p && !m_eip && (m_phase == 0);
    if (bus_addr == 16'hFF0F)      rd = {3'b111, m_if};
    else if (bus_addr == 16'hFFFF) rd = m_ie;
    else                           rd = 8'hFF;
    chk("m_rdata", 16'(bus_rdata), 16'(rd));
    chk("m_iq", 16'(interrupt_queued), 16'(m_ime && p && (m_phase == 0)));
    chk("m_iq_noime", 16'(interrupt_queued_no_IME), 16'(!m_ime && p));
    chk("m_ei_delay", 16'(enable_interrupts_delayed), 16'(m_eip));
    chk("m_halt_bug", 16'(halt_bug_delay), 16'(cond && !m_hbprev));
    chk("m_wiv", 16'(write_interrupt_vector), 16'(m_phase == 5));
    chk("m_vector", 16'(interrupt_vector), 16'(m_vec));
    chk("m_state", 16'(dispatch_state), 16'(m_phase));
    chk("m_ime", 16'(ime), 16'(m_ime));
  endtask

  // Advance the model by one M-cycle using the inputs present at the edge.
  task automatic model_update();
    bit [4:0] pend;
    bit [4:0] nif;
    bit       cond;
    int       k;
    pend = m_ie[4:0] & m_if;
    k    = lowest(pend);
    cond = halt && !m_ime && (pend != 5'd0) && !m_eip && (m_phase == 0);
    if (!reset) begin
      m_if = 0; m_ie = 0; m_ime = 0; m_eip = 0; m_phase = 0; m_vec = 0; m_hbprev = 0;
      return;
    end
    nif = m_if;
    if (bus_wren && bus_addr == 16'hFF0F) nif = bus_wdata[4:0];
    if (m_phase == 4) begin
      if (k >= 0) begin
        m_vec  = 8'h40 + 8'(8 * k);
        nif[k] = 1'b0;
      end else begin
        m_vec = 8'h00;
      end
    end
    nif = nif | irq_req;
    if (bus_wren && bus_addr == 16'hFFFF) m_ie = bus_wdata;
    if (m_phase == 0) begin
      if (m_ime && pend != 5'd0 && (last_m_cycle || halt)) begin
        m_phase = 1; m_ime = 0; m_eip = 0;
      end else if (last_m_cycle) begin
        if (di) begin
          m_ime = 0; m_eip = 0;
        end else begin
          if (reti || m_eip) m_ime = 1;
          m_eip = ei;
        end
      end
    end else begin
      m_phase = (m_phase == 5) ? 0 : m_phase + 1;
    end
    m_if     = nif;
    m_hbprev = cond;
  endtask

  task automatic step();
    @(negedge clk);
    if (chk_en) compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_idle();
    reset = 1'b1; irq_req = 5'd0; bus_addr = 16'h0000; bus_wdata = 8'h00; bus_wren = 1'b0;
    ei = 1'b0; di = 1'b0; reti = 1'b0; halt = 1'b0; last_m_cycle = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    drive_idle(); bus_wren = 1'b1; bus_addr = a; bus_wdata = d; step();
    drive_idle();
  endtask

  task automatic set_ime_by_reti();
    drive_idle(); reti = 1'b1; last_m_cycle = 1'b1; step();
    drive_idle();
  endtask

  initial begin
    int r;
    int sel;
    errors = 0; checks = 0; chk_en = 1'b0;
    drive_idle();
    reset = 1'b0;
    step(); step();
    chk_en = 1'b1;
    drive_idle();

    // Reset state
    bus_addr = 16'hFF0F; #1; chk("rst_if_read", 16'(bus_rdata), 16'hE0);
    bus_addr = 16'hFFFF; #1; chk("rst_ie_read", 16'(bus_rdata), 16'h00);
    chk("rst_iq", 16'(interrupt_queued), 16'd0);
    chk("rst_wiv", 16'(write_interrupt_vector), 16'd0);
    chk("rst_state", 16'(dispatch_state), 16'd0);
    chk("rst_ime", 16'(ime), 16'd0);
    drive_idle();

    // Basic dispatch: IE=05, requests on sources 0 and 2, source 0 wins
    bus_write(16'hFFFF, 8'h05);
    set_ime_by_reti();
    last_m_cycle = 1'b1; irq_req = 5'b00101; step();
    drive_idle(); last_m_cycle = 1'b1; #1;
    chk("basic_queued", 16'(interrupt_queued), 16'd1);
    step();
    drive_idle();
    chk("basic_wait", 16'(dispatch_state), 16'd1);
    chk("basic_iq_forced", 16'(interrupt_queued), 16'd0);
    for (int i = 0; i < 4; i++) step();
    chk("basic_jump_state", 16'(dispatch_state), 16'd5);
    chk("basic_jump_wiv", 16'(write_interrupt_vector), 16'd1);
    chk("basic_jump_vec", 16'(interrupt_vector), 16'h40);
    step();
    bus_addr = 16'hFF0F; #1; chk("basic_if_after", 16'(bus_rdata), 16'hE4);

    // EI delay: IME only rises at the following instruction's last cycle
    bus_write(16'hFFFF, 8'h01);
    bus_write(16'hFF0F, 8'h01);
    ei = 1'b1; last_m_cycle = 1'b1; step();
    drive_idle(); last_m_cycle = 1'b1; #1;
    chk("ei_window", 16'(enable_interrupts_delayed), 16'd1);
    chk("ei_no_iq", 16'(interrupt_queued), 16'd0);
    step();
    chk("ei_ime_set", 16'(ime), 16'd1);
    chk("ei_iq_after", 16'(interrupt_queued), 16'd1);
    chk("ei_still_idle", 16'(dispatch_state), 16'd0);
    step();
    drive_idle();
    chk("ei_dispatch", 16'(dispatch_state), 16'd1);
    for (int i = 0; i < 4; i++) step();
    chk("ei_vec", 16'(interrupt_vector), 16'h40);
    step();

    // Halt bug with IME clear
    bus_write(16'hFFFF, 8'h04);
    bus_write(16'hFF0F, 8'h04);
    halt = 1'b1; #1;
    chk("hb_pulse", 16'(halt_bug_delay), 16'd1);
    chk("hb_iq_noime", 16'(interrupt_queued_no_IME), 16'd1);
    step();
    chk("hb_one_cycle", 16'(halt_bug_delay), 16'd0);
    step();
    chk("hb_no_dispatch", 16'(dispatch_state), 16'd0);
    drive_idle();

    // Cancellation by an IE write during push-high
    set_ime_by_reti();
    last_m_cycle = 1'b1; step();
    drive_idle(); step(); step();
    chk("cancel_push_hi", 16'(dispatch_state), 16'd3);
    bus_wren = 1'b1; bus_addr = 16'hFFFF; bus_wdata = 8'h00; step();
    drive_idle(); step();
    chk("cancel_wiv", 16'(write_interrupt_vector), 16'd1);
    chk("cancel_vec", 16'(interrupt_vector), 16'h00);
    step();
    bus_addr = 16'hFF0F; #1; chk("cancel_if_kept", 16'(bus_rdata), 16'hE4);

    // Request on the bit being cleared at push-low survives
    bus_write(16'hFFFF, 8'h01);
    bus_write(16'hFF0F, 8'h01);
    set_ime_by_reti();
    last_m_cycle = 1'b1; step();
    drive_idle(); step(); step(); step();
    chk("race_push_lo", 16'(dispatch_state), 16'd4);
    irq_req = 5'b00001; step();
    drive_idle();
    chk("race_vec", 16'(interrupt_vector), 16'h40);
    step();
    bus_addr = 16'hFF0F; #1; chk("race_if_kept", 16'(bus_rdata), 16'hE1);

    // Reset during DEC_SP aborts without a vector write
    set_ime_by_reti();
    last_m_cycle = 1'b1; step();
    drive_idle(); step();
    chk("abort_dec_sp", 16'(dispatch_state), 16'd2);
    reset = 1'b0; step();
    drive_idle();
    chk("abort_idle", 16'(dispatch_state), 16'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_wiv", 16'(write_interrupt_vector), 16'd0);
    end

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      drive_idle();
      reset = ($urandom_range(0, 199) != 0);
      r = $urandom_range(0, 15);
      ei = (r == 0); di = (r == 1); reti = (r == 2); halt = (r == 3);
      last_m_cycle = ($urandom_range(0, 2) != 0);
      irq_req = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      bus_wren = ($urandom_range(0, 5) == 0);
      sel = $urandom_range(0, 3);
      bus_addr = (sel == 0) ? 16'hFF0F : (sel == 1) ? 16'hFFFF : (sel == 2) ? 16'hC000 : 16'hFF0E;
      bus_wdata = 8'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
